// File: rtl/blocpu_pkg.sv
// Shared types and constants for the blocpu program-load/run sequencer.
package blocpu_pkg;

  localparam int unsigned INSTR_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    START,
    RUN,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_FORMAT  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/blocpu_run_timer.sv
// Run-cycle counter with synchronous clear, count enable and terminal-count flag.
module blocpu_run_timer #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + CNT_W'(1);
  end

  // High during the last cycle the run is allowed.
  assign tc = (count == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/blocpu_load_ctrl.sv
// Host byte-stream loader for blocpu_core instruction memory plus run/halt/timeout sequencing.
module blocpu_load_ctrl
  import blocpu_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned INSTR_W    = blocpu_pkg::INSTR_W,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               host_valid,
  input  logic [7:0]         host_data,
  output logic               host_ready,
  input  logic               abort_i,
  input  logic               clear_i,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               run_o,
  input  logic               core_halt_i,
  output logic               done_o,
  output logic               err_o,
  output logic [1:0]         err_code,
  output logic [CNT_W-1:0]   cycles_o,
  output logic               busy_o
);

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

  state_t              state, state_nx;
  logic [7:0]          left, left_nx;
  logic [ADDR_W-1:0]   addr, addr_nx;
  logic [7:0]          low, low_nx;
  logic [1:0]          err_q, err_nx;
  logic [CNT_W-1:0]    cycles_nx;
  logic                we_nx;
  logic [ADDR_W-1:0]   waddr_nx;
  logic [INSTR_W-1:0]  wdata_nx;
  logic [CNT_W-1:0]    run_count;
  logic                run_tc;
  logic                xfer;

  blocpu_run_timer #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == START),
    .en    (state == RUN),
    .count (run_count),
    .tc    (run_tc)
  );

  // Gated by rst_n so the host sees no ready while reset is held.
  assign host_ready = rst_n && (state == IDLE || state == LO || state == HI);
  assign xfer       = host_valid && host_ready;
  assign run_o      = (state == RUN);
  assign done_o     = (state == DONE);
  assign err_o      = (state == ERR);
  assign busy_o     = (state != IDLE);
  assign err_code   = err_q;

  always_comb begin
    state_nx  = state;
    left_nx   = left;
    addr_nx   = addr;
    low_nx    = low;
    err_nx    = err_q;
    cycles_nx = cycles_o;
    we_nx     = 1'b0;
    waddr_nx  = im_addr;
    wdata_nx  = im_wdata;
    case (state)
      IDLE: if (xfer && host_data != 8'd0) begin
        if ({24'd0, host_data} > MAX_WORDS) begin
          state_nx = ERR;
          err_nx   = ERR_FORMAT;
        end else begin
          left_nx  = host_data;
          addr_nx  = '0;
          state_nx = LO;
        end
      end
      LO: if (xfer) begin
        low_nx   = host_data;
        state_nx = HI;
      end
      HI: if (xfer) begin
        if (host_data[7:4] != 4'd0) begin
          state_nx = ERR;
          err_nx   = ERR_FORMAT;
        end else begin
          we_nx    = 1'b1;
          waddr_nx = addr;
          wdata_nx = INSTR_W'({host_data[3:0], low});
          if (left == 8'd1) begin
            state_nx = START;
          end else begin
            left_nx  = left - 8'd1;
            addr_nx  = addr + ADDR_W'(1);
            state_nx = LO;
          end
        end
      end
      START: begin
        cycles_nx = '0;
        state_nx  = RUN;
      end
      RUN: if (core_halt_i) begin
        cycles_nx = run_count + CNT_W'(1);
        state_nx  = DONE;
      end else if (run_tc) begin
        cycles_nx = run_count + CNT_W'(1);
        state_nx  = ERR;
        err_nx    = ERR_TIMEOUT;
      end
      DONE: state_nx = IDLE;
      ERR: if (clear_i) begin
        state_nx = IDLE;
        err_nx   = ERR_NONE;
      end
      default: state_nx = IDLE;
    endcase
    // Abort overrides everything decided above, including a write being accepted this cycle.
    if (abort_i && state != ERR) begin
      state_nx  = IDLE;
      err_nx    = ERR_NONE;
      cycles_nx = cycles_o;
      we_nx     = 1'b0;
      waddr_nx  = im_addr;
      wdata_nx  = im_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      left     <= '0;
      addr     <= '0;
      low      <= '0;
      err_q    <= ERR_NONE;
      cycles_o <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
    end else begin
      state    <= state_nx;
      left     <= left_nx;
      addr     <= addr_nx;
      low      <= low_nx;
      err_q    <= err_nx;
      cycles_o <= cycles_nx;
      im_we    <= we_nx;
      im_addr  <= waddr_nx;
      im_wdata <= wdata_nx;
    end
  end

endmodule

// File: tb/tb_blocpu_load_ctrl.sv
// Randomised self-checking bench for blocpu_load_ctrl (default build and a small ADDR_W=3/MAX_CYCLES=16 build).
module tb_blocpu_load_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic host_valid = 1'b0;
  logic [7:0] host_data = 8'd0;
  logic abort_i = 1'b0, clear_i = 1'b0, core_halt_i = 1'b0;
  logic sel = 1'b0;

  logic a_ready, a_we, a_run, a_done, a_err, a_busy;
  logic [7:0] a_addr; logic [11:0] a_wdata; logic [1:0] a_code; logic [15:0] a_cycles;
  logic b_ready, b_we, b_run, b_done, b_err, b_busy;
  logic [2:0] b_addr; logic [11:0] b_wdata; logic [1:0] b_code; logic [15:0] b_cycles;

  logic o_ready, o_we, o_run, o_done, o_err, o_busy;
  logic [7:0] o_addr; logic [11:0] o_wdata; logic [1:0] o_code; logic [15:0] o_cycles;

  always #5 clk = ~clk;

  blocpu_load_ctrl #(.ADDR_W(8), .INSTR_W(12), .CNT_W(16), .MAX_CYCLES(65535)) dut_a (
    .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_data(host_data), .host_ready(a_ready),
    .abort_i(abort_i), .clear_i(clear_i), .im_we(a_we), .im_addr(a_addr), .im_wdata(a_wdata),
    .run_o(a_run), .core_halt_i(core_halt_i), .done_o(a_done), .err_o(a_err), .err_code(a_code),
    .cycles_o(a_cycles), .busy_o(a_busy));

  blocpu_load_ctrl #(.ADDR_W(3), .INSTR_W(12), .CNT_W(16), .MAX_CYCLES(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_data(host_data), .host_ready(b_ready),
    .abort_i(abort_i), .clear_i(clear_i), .im_we(b_we), .im_addr(b_addr), .im_wdata(b_wdata),
    .run_o(b_run), .core_halt_i(core_halt_i), .done_o(b_done), .err_o(b_err), .err_code(b_code),
    .cycles_o(b_cycles), .busy_o(b_busy));

  assign o_ready  = sel ? b_ready  : a_ready;
  assign o_we     = sel ? b_we     : a_we;
  assign o_run    = sel ? b_run    : a_run;
  assign o_done   = sel ? b_done   : a_done;
  assign o_err    = sel ? b_err    : a_err;
  assign o_busy   = sel ? b_busy   : a_busy;
  assign o_addr   = sel ? {5'd0, b_addr} : a_addr;
  assign o_wdata  = sel ? b_wdata  : a_wdata;
  assign o_code   = sel ? b_code   : a_code;
  assign o_cycles = sel ? b_cycles : a_cycles;

  int n_checks = 0;
  int n_pass = 0;
  logic [19:0] wq[$];
  int run_cnt = 0, done_cnt = 0, rdy_run = 0, busy_cnt = 0;
  logic [11:0] words [0:255];

  always @(negedge clk) begin
    if (o_we) wq.push_back({o_addr, o_wdata});
    if (o_run) run_cnt++;
    if (o_done) done_cnt++;
    if (o_ready && o_run) rdy_run++;
    if (o_busy) busy_cnt++;
  end

  task automatic mon_clear();
    wq.delete();
    run_cnt = 0; done_cnt = 0; rdy_run = 0; busy_cnt = 0;
  endtask

  function automatic int gap_len(input int gm);
    if (gm == 0) return 0;
    if (gm == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  // Called at a negedge; the byte transfers on the posedge after a negedge that shows host_ready.
  task automatic send_byte(input logic [7:0] b, input int gap);
    host_valid = 1'b0;
    repeat (gap) @(negedge clk);
    host_data = b;
    host_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      if (o_ready) begin
        @(negedge clk);
        host_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    host_valid = 1'b0;
    n_checks++;
    $display("FAIL send_byte: host_ready never seen for byte %0h", b);
  endtask

  task automatic load(input int n, input int gm);
    send_byte(8'(n), gap_len(gm));
    for (int i = 0; i < n; i++) begin
      send_byte(words[i][7:0], gap_len(gm));
      send_byte({4'd0, words[i][11:8]}, gap_len(gm));
    end
  endtask

  task automatic run_phase(input int k, input bit with_abort);
    int i;
    bit seen;
    i = 0;
    seen = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (o_run) begin
        seen = 1'b1;
        i++;
        if (i == k) begin
          core_halt_i = 1'b1;
          abort_i = with_abort;
        end
      end else begin
        core_halt_i = 1'b0;
        abort_i = 1'b0;
        if (seen) break;
      end
    end
    core_halt_i = 1'b0;
    abort_i = 1'b0;
    if (!seen || o_run) begin
      n_checks++;
      $display("FAIL run_phase: run window seen=%0d still_running=%0d required 1/0", seen, o_run);
    end
  endtask

  task automatic resync();
    abort_i = 1'b1; clear_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0; clear_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_directed();
    logic [11:0] d [0:7];
    d = '{12'h100, 12'h700, 12'hF00, 12'hC00, 12'h901, 12'h50A, 12'h301, 12'hF13};
    for (int i = 0; i < 8; i++) words[i] = d[i];
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if ({o_ready, o_we, o_run, o_done, o_err, o_busy, o_code, o_cycles, o_addr, o_wdata} !== '0)
      $display("FAIL reset_outputs: got %0h required 0", {o_ready, o_we, o_run, o_done, o_err, o_busy, o_code, o_cycles, o_addr, o_wdata});
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (o_ready !== 1'b1) $display("FAIL reset_ready_after: got %0b required 1", o_ready); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy_after: got %0b required 0", o_busy); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_directed(input int gm);
    int bad;
    sel = 1'b0;
    resync();
    set_directed();
    mon_clear();
    load(8, gm);
    run_phase(20, 1'b0);
    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 8; i++) if (i >= wq.size() || wq[i] !== {8'(i), words[i]}) bad++;
    n_checks++; if (wq.size() != 8) $display("FAIL dir%0d_write_count: got %0d required 8", gm, wq.size()); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL dir%0d_write_data: got %0d bad entries required 0", gm, bad); else n_pass++;
    n_checks++; if (run_cnt != 20) $display("FAIL dir%0d_run_cycles: got %0d required 20", gm, run_cnt); else n_pass++;
    n_checks++; if (o_cycles !== 16'd20) $display("FAIL dir%0d_cycles_o: got %0d required 20", gm, o_cycles); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL dir%0d_done_pulses: got %0d required 1", gm, done_cnt); else n_pass++;
    n_checks++; if (o_err !== 1'b0) $display("FAIL dir%0d_err: got %0b required 0", gm, o_err); else n_pass++;
    n_checks++; if (rdy_run != 0) $display("FAIL dir%0d_ready_in_run: got %0d required 0", gm, rdy_run); else n_pass++;
  endtask

  task automatic test_format();
    sel = 1'b0;
    resync();
    mon_clear();
    send_byte(8'd1, 0);
    send_byte(8'h34, 0);
    send_byte(8'h52, 0);
    n_checks++; if (o_err !== 1'b1) $display("FAIL fmt_err: got %0b required 1", o_err); else n_pass++;
    n_checks++; if (o_code !== 2'd1) $display("FAIL fmt_code: got %0d required 1", o_code); else n_pass++;
    n_checks++; if (o_ready !== 1'b0) $display("FAIL fmt_ready_in_err: got %0b required 0", o_ready); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (wq.size() != 0) $display("FAIL fmt_no_write: got %0d writes required 0", wq.size()); else n_pass++;
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    n_checks++; if ({o_err, o_code, o_busy} !== 4'd0) $display("FAIL fmt_clear: got err=%0b code=%0d busy=%0b required 0/0/0", o_err, o_code, o_busy); else n_pass++;
    sel = 1'b1;
    send_byte(8'd9, 0);
    n_checks++; if ({o_err, o_code} !== 3'b101) $display("FAIL fmt_count_too_big: got err=%0b code=%0d required 1/1", o_err, o_code); else n_pass++;
  endtask

  task automatic test_timeout();
    sel = 1'b1;
    resync();
    for (int i = 0; i < 3; i++) words[i] = 12'($urandom);
    mon_clear();
    load(3, 0);
    run_phase(1000, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++; if (run_cnt != 16) $display("FAIL to_run_cycles: got %0d required 16", run_cnt); else n_pass++;
    n_checks++; if (o_cycles !== 16'd16) $display("FAIL to_cycles_o: got %0d required 16", o_cycles); else n_pass++;
    n_checks++; if ({o_err, o_code} !== 3'b110) $display("FAIL to_err: got err=%0b code=%0d required 1/2", o_err, o_code); else n_pass++;
    n_checks++; if (done_cnt != 0) $display("FAIL to_no_done: got %0d required 0", done_cnt); else n_pass++;
    resync();
    mon_clear();
    load(3, 0);
    run_phase(16, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++; if (done_cnt != 1) $display("FAIL to_edge_done: got %0d required 1", done_cnt); else n_pass++;
    n_checks++; if (o_err !== 1'b0) $display("FAIL to_edge_err: got %0b required 0", o_err); else n_pass++;
    n_checks++; if (o_cycles !== 16'd16) $display("FAIL to_edge_cycles_o: got %0d required 16", o_cycles); else n_pass++;
  endtask

  task automatic test_zero_and_abort();
    sel = 1'b0;
    resync();
    mon_clear();
    send_byte(8'd0, 0);
    repeat (4) @(negedge clk);
    n_checks++; if (busy_cnt != 0 || wq.size() != 0 || run_cnt != 0)
      $display("FAIL zero_count: got busy=%0d writes=%0d run=%0d required 0/0/0", busy_cnt, wq.size(), run_cnt);
    else n_pass++;
    for (int i = 0; i < 4; i++) words[i] = 12'($urandom);
    mon_clear();
    load(4, 0);
    run_phase(5, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++; if (run_cnt != 5) $display("FAIL abort_run_cycles: got %0d required 5", run_cnt); else n_pass++;
    n_checks++; if (done_cnt != 0) $display("FAIL abort_no_done: got %0d required 0", done_cnt); else n_pass++;
    n_checks++; if ({o_run, o_busy, o_err} !== 3'b000) $display("FAIL abort_idle: got run=%0b busy=%0b err=%0b required 0/0/0", o_run, o_busy, o_err); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int i;
    int bad;
    sel = 1'b0;
    resync();
    for (int j = 0; j < 3; j++) words[j] = 12'($urandom);
    load(3, 0);
    i = 0;
    for (int t = 0; t < 100 && i < 5; t++) begin
      @(negedge clk);
      if (o_run) i++;
    end
    n_checks++; if (i != 5) $display("FAIL rst_reach_run5: got %0d required 5", i); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({o_run, o_busy, o_done, o_err} !== 4'd0)
      $display("FAIL rst_mid_run: got run=%0b busy=%0b done=%0b err=%0b required 0", o_run, o_busy, o_done, o_err);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 5; j++) words[j] = 12'($urandom);
    mon_clear();
    load(5, 2);
    run_phase(7, 1'b0);
    repeat (3) @(negedge clk);
    bad = 0;
    for (int j = 0; j < 5; j++) if (j >= wq.size() || wq[j] !== {8'(j), words[j]}) bad++;
    n_checks++; if (wq.size() != 5 || bad != 0) $display("FAIL rst_reload_writes: got %0d writes %0d bad required 5/0", wq.size(), bad); else n_pass++;
    n_checks++; if (o_cycles !== 16'd7 || done_cnt != 1) $display("FAIL rst_reload_run: got cycles=%0d done=%0d required 7/1", o_cycles, done_cnt); else n_pass++;
  endtask

  task automatic test_random();
    int n, k, maxc, exp_run, bad;
    bit exp_done;
    for (int it = 0; it < 8; it++) begin
      sel = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 8));
      k = int'($urandom_range(1, 24));
      for (int i = 0; i < n; i++) words[i] = 12'($urandom);
      resync();
      mon_clear();
      load(n, 2);
      run_phase(k, 1'b0);
      repeat (3) @(negedge clk);
      maxc = sel ? 16 : 65535;
      exp_done = (k <= maxc);
      exp_run = exp_done ? k : maxc;
      bad = 0;
      for (int i = 0; i < n; i++) if (i >= wq.size() || wq[i] !== {8'(i), words[i]}) bad++;
      n_checks++; if (wq.size() != n || bad != 0) $display("FAIL rnd%0d_writes: got %0d writes %0d bad required %0d/0", it, wq.size(), bad, n); else n_pass++;
      n_checks++; if (run_cnt != exp_run) $display("FAIL rnd%0d_run_cycles: got %0d required %0d", it, run_cnt, exp_run); else n_pass++;
      n_checks++; if (o_cycles !== 16'(exp_run)) $display("FAIL rnd%0d_cycles_o: got %0d required %0d", it, o_cycles, exp_run); else n_pass++;
      n_checks++; if (done_cnt != int'(exp_done)) $display("FAIL rnd%0d_done: got %0d required %0d", it, done_cnt, exp_done); else n_pass++;
      n_checks++; if (o_code !== (exp_done ? 2'd0 : 2'd2)) $display("FAIL rnd%0d_err_code: got %0d required %0d", it, o_code, exp_done ? 0 : 2); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed(0);
    test_directed(1);
    test_format();
    test_timeout();
    test_zero_and_abort();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
